// File: rtl/pcw_pkg.sv
// pcw_pkg: shared boot sequencer state encoding and boot image length
package pcw_pkg;
  typedef enum logic [2:0] {IDLE, BOOT_RD, BOOT_WR, BOOT_EXEC, HPS} boot_state_t;
  localparam int BOOT_ROM_LEN = 276;
endpackage

// File: rtl/pcw_boot_sequencer.sv
// pcw_boot_sequencer: copies the boot ROM into core RAM on kick and arbitrates the download port with HPS
module pcw_boot_sequencer
  import pcw_pkg::*;
#(
  parameter int          ROM_LEN   = BOOT_ROM_LEN,
  parameter logic [15:0] EXEC_ADDR = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        kick,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic        dn_go,
  output logic        dn_wr,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  input  logic        dn_wait,
  output logic [15:0] execute_addr,
  output logic        execute_enable,
  output logic        busy
);
  localparam logic [15:0] LAST = 16'(ROM_LEN - 1);
  boot_state_t state, state_n;
  logic [15:0] idx, idx_n, hps_addr;
  logic [7:0]  data_q, hps_data;
  logic        pending, held, hps_go, hps_wr;

  // next state and boot index; kick always restarts the copy from address 0
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: begin
        if (kick || (pending && !ioctl_download)) begin
          state_n = BOOT_RD;
          idx_n = '0;
        end else if (ioctl_download) state_n = HPS;
      end
      BOOT_RD: begin
        state_n = kick ? BOOT_RD : BOOT_WR;
        idx_n = kick ? '0 : idx;
      end
      BOOT_WR: begin
        if (kick) begin
          state_n = BOOT_RD;
          idx_n = '0;
        end else if (!dn_wait) begin
          state_n = (idx == LAST) ? BOOT_EXEC : BOOT_RD;
          idx_n = (idx == LAST) ? idx : idx + 16'd1;
        end
      end
      BOOT_EXEC: begin
        state_n = kick ? BOOT_RD : IDLE;
        idx_n = '0;
      end
      HPS: begin
        if (!ioctl_download && !hps_wr) begin
          state_n = (pending || kick) ? BOOT_RD : IDLE;
          idx_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register; a kick seen during HPS is remembered until the boot starts
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pending <= (state_n != BOOT_RD) && (pending || (kick && state == HPS));
    end
  end

  // ROM byte is latched in the first BOOT_WR cycle so a stall holds it; HPS bytes are registered on strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      held <= 1'b0;
      data_q <= '0;
      hps_go <= 1'b0;
      hps_wr <= 1'b0;
      hps_addr <= '0;
      hps_data <= '0;
    end else begin
      held <= state == BOOT_WR && state_n == BOOT_WR;
      if (state == BOOT_WR && !held) data_q <= rom_data;
      hps_go <= state_n == HPS && ioctl_download;
      hps_wr <= state == HPS && (ioctl_wr || (hps_wr && dn_wait));
      if (state == HPS && ioctl_wr) begin
        hps_addr <= ioctl_addr;
        hps_data <= ioctl_data;
      end
    end
  end

  assign rom_addr       = state == BOOT_RD ? idx : '0;
  assign dn_go          = state == BOOT_RD || state == BOOT_WR || (state == HPS && hps_go);
  assign dn_wr          = state == BOOT_WR || (state == HPS && hps_wr);
  assign dn_addr        = state == BOOT_WR ? idx : state == HPS ? hps_addr : '0;
  assign dn_data        = state == BOOT_WR ? (held ? data_q : rom_data) : state == HPS ? hps_data : '0;
  assign ioctl_wait     = state == HPS ? (dn_wait || hps_wr) : ioctl_download;
  assign execute_addr   = EXEC_ADDR;
  assign execute_enable = state == BOOT_EXEC;
  assign busy           = state != IDLE;
endmodule

// File: tb/tb_pcw_boot_sequencer.sv
// tb_pcw_boot_sequencer: directed vector bench for the boot sequencer with a 4-byte ROM
module tb_pcw_boot_sequencer;
  localparam logic [15:0] EA = 16'hC000;
  typedef struct {
    logic        kick;
    logic        dwait;
    logic [4:0]  flags;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] rom;
  } vec_t;
  logic clk_sys = 1'b0, reset_n = 1'b0, kick = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0, dn_wait = 1'b0;
  logic [15:0] ioctl_addr = '0, rom_addr, dn_addr, execute_addr;
  logic [7:0]  ioctl_data = '0, rom_data = '0, dn_data;
  logic        ioctl_wait, dn_go, dn_wr, execute_enable, busy;
  logic [7:0]  rom [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [23:0] wlog [$];
  int total = 0, bad = 0, cyc = 0, exec_n = 0, exec_cyc = -1, overlap = 0;

  pcw_boot_sequencer #(.ROM_LEN(4), .EXEC_ADDR(EA)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kick(kick), .rom_addr(rom_addr), .rom_data(rom_data),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wait(dn_wait), .execute_addr(execute_addr), .execute_enable(execute_enable), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    rom_data <= rom[rom_addr[1:0]];
  end

  always @(negedge clk_sys) begin
    if (dn_wr && !dn_wait) wlog.push_back({dn_addr, dn_data});
    if (execute_enable) begin
      exec_n++;
      exec_cyc = cyc;
    end
    if (execute_enable && dn_go) overlap++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_sys);
  endtask

  function automatic logic [63:0] obs();
    return 64'({busy, dn_go, dn_wr, execute_enable, ioctl_wait, dn_addr, dn_data, rom_addr});
  endfunction

  task automatic chk_log(input string name, input int start, input logic [23:0] ex [$]);
    chk({name, "_count"}, 64'(wlog.size() - start), 64'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s_w%0d", name, i), 64'((start + i < wlog.size()) ? wlog[start + i] : 24'hxxxxxx), 64'(ex[i]));
  endtask

  initial begin
    vec_t tv [11];
    logic [23:0] boot4 [$];
    int s, e, base;
    boot4 = '{24'h0000A0, 24'h0001A1, 24'h0002A2, 24'h0003A3};
    tv[0]  = '{1'b1, 1'b0, 5'b00000, 16'h0, 8'h00, 16'h0};
    tv[1]  = '{1'b0, 1'b0, 5'b11000, 16'h0, 8'h00, 16'h0};
    tv[2]  = '{1'b0, 1'b0, 5'b11100, 16'h0, 8'hA0, 16'h0};
    tv[3]  = '{1'b0, 1'b0, 5'b11000, 16'h0, 8'h00, 16'h1};
    tv[4]  = '{1'b0, 1'b0, 5'b11100, 16'h1, 8'hA1, 16'h0};
    tv[5]  = '{1'b0, 1'b0, 5'b11000, 16'h0, 8'h00, 16'h2};
    tv[6]  = '{1'b0, 1'b0, 5'b11100, 16'h2, 8'hA2, 16'h0};
    tv[7]  = '{1'b0, 1'b0, 5'b11000, 16'h0, 8'h00, 16'h3};
    tv[8]  = '{1'b0, 1'b0, 5'b11100, 16'h3, 8'hA3, 16'h0};
    tv[9]  = '{1'b0, 1'b0, 5'b10010, 16'h0, 8'h00, 16'h0};
    tv[10] = '{1'b0, 1'b0, 5'b00000, 16'h0, 8'h00, 16'h0};

    tick();
    tick();
    samp();
    chk("reset_outputs", obs(), 64'd0);
    chk("reset_exec_addr", 64'(execute_addr), 64'(EA));
    tick();
    reset_n = 1'b1;
    tick();

    s = wlog.size();
    e = exec_n;
    for (int i = 0; i < 11; i++) begin
      tick();
      kick = tv[i].kick;
      dn_wait = tv[i].dwait;
      samp();
      chk($sformatf("t1_c%0d", i), obs(), 64'({tv[i].flags, tv[i].addr, tv[i].data, tv[i].rom}));
    end
    chk_log("t1_log", s, boot4);
    chk("t1_exec_count", 64'(exec_n - e), 64'd1);

    s = wlog.size();
    e = exec_n;
    base = 0;
    for (int c = 0; c <= 13; c++) begin
      tick();
      if (c == 0) base = cyc;
      kick = c == 0;
      dn_wait = c >= 4 && c <= 6;
      samp();
      if (c >= 4 && c <= 7) chk($sformatf("t2_hold_c%0d", c), 64'({dn_wr, dn_addr, dn_data}), 64'({1'b1, 16'h0001, 8'hA1}));
    end
    dn_wait = 1'b0;
    chk("t2_exec_cycle", 64'(exec_cyc - base), 64'd12);
    chk("t2_exec_count", 64'(exec_n - e), 64'd1);
    chk_log("t2_log", s, boot4);

    s = wlog.size();
    e = exec_n;
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (c == 0) base = cyc;
      kick = c == 0;
      ioctl_download = c >= 2 && c < 13;
      ioctl_wr = c == 11;
      ioctl_addr = 16'h1234;
      ioctl_data = 8'h55;
      samp();
      if (c >= 2 && c <= 10) chk($sformatf("t3_wait_c%0d", c), 64'(ioctl_wait), 64'd1);
      if (c == 11) chk("t3_hps_ready", 64'(ioctl_wait), 64'd0);
      if (c == 12) chk("t3_hps_wr", 64'({dn_go, dn_wr, dn_addr, dn_data, ioctl_wait}), 64'({1'b1, 1'b1, 16'h1234, 8'h55, 1'b1}));
      if (c == 13) chk("t3_hps_clr", 64'(dn_wr), 64'd0);
      if (c == 14) chk("t3_idle", 64'(busy), 64'd0);
    end
    chk("t3_exec_cycle", 64'(exec_cyc - base), 64'd9);
    chk("t3_exec_count", 64'(exec_n - e), 64'd1);
    chk_log("t3_log", s, '{24'h0000A0, 24'h0001A1, 24'h0002A2, 24'h0003A3, 24'h123455});

    s = wlog.size();
    e = exec_n;
    for (int c = 0; c <= 20; c++) begin
      tick();
      if (c == 0) base = cyc;
      ioctl_download = c < 4;
      kick = c == 2;
      samp();
      if (c == 3) chk("t4a_no_boot_in_hps", 64'({dn_wr, execute_enable}), 64'd0);
      if (c == 6) chk("t4a_first_wr", 64'({dn_wr, dn_addr, dn_data}), 64'({1'b1, 16'h0000, 8'hA0}));
    end
    chk("t4a_exec_cycle", 64'(exec_cyc - base), 64'd13);
    chk("t4a_exec_count", 64'(exec_n - e), 64'd1);
    chk_log("t4a_log", s, boot4);

    s = wlog.size();
    e = exec_n;
    for (int c = 0; c <= 18; c++) begin
      tick();
      if (c == 0) base = cyc;
      kick = c == 0 || c == 5;
      samp();
      if (c == 6) chk("t4b_restart_rd", 64'({dn_go, dn_wr, rom_addr}), 64'({1'b1, 1'b0, 16'h0000}));
    end
    chk("t4b_exec_cycle", 64'(exec_cyc - base), 64'd14);
    chk("t4b_exec_count", 64'(exec_n - e), 64'd1);
    chk_log("t4b_log", s, '{24'h0000A0, 24'h0001A1, 24'h0000A0, 24'h0001A1, 24'h0002A2, 24'h0003A3});

    s = wlog.size();
    e = exec_n;
    tick();
    kick = 1'b1;
    tick();
    kick = 1'b0;
    tick();
    chk("t5_in_write", 64'({dn_wr, dn_addr}), 64'({1'b1, 16'h0000}));
    #1 reset_n = 1'b0;
    #1 chk("t5_reset_outputs", obs(), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    samp();
    chk("t5_no_exec", 64'(exec_n - e), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_no_writes", 64'(wlog.size() - s), 64'd0);
    chk("exec_vs_go_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
